// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready packer of decoded fields into RV64 I/S/B words.
// Optional INSTR_ENC_SELFCHECK_EN re-extracts the immediate from each word and flags disagreement.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count,
  output logic             chk_fail
);
  logic             s1_valid_q, out_valid_q, out_err_q, err_d;
  logic [1:0]       fmt_q;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [2:0]       f3_q;
  logic [5:0]       f7_q;
  logic [63:0]      imm_q;
  logic [31:0]      out_instr_q, instr_d;
  logic [6:0]       opcode;
  logic [CNT_W-1:0] enc_count_q, err_count_q;
  logic             s2_load, accept, hs, shift, unused_ok;
  assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid_q && out_ready;
  assign unused_ok = in_funct7[0];
  // funct3 001 and 101 are the RV64 shift encodings with a 6-bit shamt
  assign shift  = fmt_q == 2'd0 && f3_q[1:0] == 2'b01;
  assign opcode = fmt_q == 2'd0 ? 7'h13 : fmt_q == 2'd1 ? 7'h03 : fmt_q == 2'd2 ? 7'h23 : 7'h63;
  assign instr_d = fmt_q == 2'd3 ? {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], opcode}
                 : fmt_q == 2'd2 ? {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], opcode}
                 : shift         ? {f7_q, imm_q[5:0], rs1_q, f3_q, rd_q, opcode}
                 :                 {imm_q[11:0], rs1_q, f3_q, rd_q, opcode};
  assign err_d = fmt_q == 2'd3 ? !(&imm_q[63:12] || ~|imm_q[63:12]) || imm_q[0]
               : shift         ? |imm_q[63:6]
               :                 !(&imm_q[63:11] || ~|imm_q[63:11]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      fmt_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      f3_q        <= '0;
      f7_q        <= '0;
      imm_q       <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= accept ? 1'b1 : s2_load ? 1'b0 : s1_valid_q;
      out_valid_q <= s2_load ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
      if (accept) begin
        fmt_q <= in_fmt;
        rd_q  <= in_rd;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        f3_q  <= in_funct3;
        f7_q  <= in_funct7[6:1];
        imm_q <= in_imm;
      end
      if (s2_load) begin
        out_instr_q <= instr_d;
        out_err_q   <= err_d;
      end
      enc_count_q <= enc_count_q + CNT_W'(hs && !(&enc_count_q));
      err_count_q <= err_count_q + CNT_W'(hs && out_err_q && !(&err_count_q));
    end
  end
`ifdef INSTR_ENC_SELFCHECK_EN
  logic [63:0] cap_imm_q, rex;
  logic        chk_fail_q, is_sh, mism;
  assign rex   = out_instr_q[6:0] == 7'h63 ? {{51{out_instr_q[31]}}, out_instr_q[31], out_instr_q[7], out_instr_q[30:25], out_instr_q[11:8], 1'b0}
               : out_instr_q[6:0] == 7'h23 ? {{52{out_instr_q[31]}}, out_instr_q[31:25], out_instr_q[11:7]}
               :                             {{52{out_instr_q[31]}}, out_instr_q[31:20]};
  assign is_sh = out_instr_q[6:0] == 7'h13 && out_instr_q[13:12] == 2'b01;
  assign mism  = is_sh ? out_instr_q[25:20] != cap_imm_q[5:0] : rex != cap_imm_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_imm_q  <= '0;
      chk_fail_q <= 1'b0;
    end else begin
      if (s2_load) cap_imm_q <= imm_q;
      chk_fail_q <= chk_fail_q || (hs && !out_err_q && mism);
    end
  end
  assign chk_fail = chk_fail_q;
`else
  assign chk_fail = 1'b0;
`endif
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table, hand-written pipeline sequences and a
// randomized scoreboard run against an arithmetic encoding model.
module tb_instr_encoder;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err, chk_fail;
  logic [1:0]    in_fmt = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [63:0]   in_imm = '0;
  logic [31:0]   out_instr;
  logic [CW-1:0] enc_count, err_count;
  int n_pass = 0, n_tot = 0, n_enc = 0, n_err = 0;
  logic mon_en = 1'b0;
  logic [32:0] sbq[$];

  typedef struct {
    logic [1:0] fmt; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [6:0] f7;
    logic [63:0] imm; logic [31:0] ei; logic ee; string nm;
  } vec_t;

  instr_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count), .chk_fail(chk_fail)
  );

  always #5 clk = ~clk;

  // Reference: fields placed by shift/mask arithmetic, ranges checked as signed integers
  function automatic logic [32:0] model(input logic [1:0] fmt, input logic [4:0] rd, rs1, rs2,
                                        input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm);
    longint v, r, op;
    logic err;
    v  = imm;
    op = fmt == 0 ? 'h13 : fmt == 1 ? 'h03 : fmt == 2 ? 'h23 : 'h63;
    r  = (longint'(rs1) << 15) | (longint'(f3) << 12) | op;
    if (fmt == 0 && (f3 == 1 || f3 == 5)) begin
      r = r | ((longint'(f7) >> 1) << 26) | ((v & 63) << 20) | (longint'(rd) << 7);
      err = v < 0 || v > 63;
    end else if (fmt < 2) begin
      r = r | ((v & 'hFFF) << 20) | (longint'(rd) << 7);
      err = v < -2048 || v > 2047;
    end else if (fmt == 2) begin
      r = r | (((v >> 5) & 'h7F) << 25) | (longint'(rs2) << 20) | ((v & 31) << 7);
      err = v < -2048 || v > 2047;
    end else begin
      r = r | (((v >> 12) & 1) << 31) | (((v >> 5) & 63) << 25) | (longint'(rs2) << 20)
            | (((v >> 1) & 15) << 8) | (((v >> 11) & 1) << 7);
      err = v < -4096 || v > 4094 || (v & 1) != 0;
    end
    return {err, r[31:0]};
  endfunction

  function automatic vec_t mk(input logic [1:0] fmt, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input longint imm, input logic [31:0] ei, input logic ee, input string nm);
    vec_t v;
    v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.ei = ei; v.ee = ee; v.nm = nm;
    return v;
  endfunction

  task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act === exp) begin
      n_tot++;
      n_pass++;
    end else fail(nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm; in_valid = 1'b1;
  endtask

  task automatic push(input vec_t v);
    int k;
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    if (!in_ready) fail({v.nm, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends one bundle with the consumer ready and checks the 2-cycle latency and the word
  task automatic send(input vec_t v);
    out_ready = 1'b1;
    push(v);
    @(negedge clk);
    chk({v.nm, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({v.nm, "_lat2"}, out_valid, 1);
    chk({v.nm, "_instr"}, out_instr, v.ei);
    chk({v.nm, "_err"}, out_err, v.ee);
  endtask

  function automatic logic [63:0] rand_imm();
    longint edges[10] = '{-2048, 2047, 2048, -2049, 4094, 4096, -4096, -4098, 63, 64};
    case ($urandom_range(3))
      0: return 64'(longint'($urandom_range(10000)) - 5000);
      1: return {$urandom, $urandom};
      2: return 64'(edges[$urandom_range(9)]);
      default: return 64'(longint'($urandom_range(200)) - 100);
    endcase
  endfunction

  always @(negedge clk) begin
    logic [32:0] e;
    if (mon_en && rst_n) begin
      if (in_valid && in_ready)
        sbq.push_back(model(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) fail("rnd_spurious_word", {out_err, out_instr}, 0);
        else begin
          e = sbq.pop_front();
          chk("rnd_word", {out_err, out_instr}, e);
          n_enc++;
          if (e[32]) n_err++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    vec_t b[3];
    logic [32:0] m[3];
    tbl[0]  = mk(0, 5, 6, 0, 0, 0, -1,    32'hFFF30293, 0, "addi");
    tbl[1]  = mk(2, 0, 2, 7, 3, 0, 8,     32'h00713423, 0, "sd");
    tbl[2]  = mk(3, 0, 1, 2, 0, 0, -4,    32'hFE208EE3, 0, "beq");
    tbl[3]  = mk(3, 0, 1, 2, 0, 0, -3,    32'hFE208EE3, 1, "beq_odd");
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 2048,  32'h80000013, 1, "i_ovf");
    tbl[5]  = mk(0, 1, 2, 0, 1, 0, 63,    32'h03F11093, 0, "slli");
    tbl[6]  = mk(0, 3, 4, 0, 5, 7'h20, 3, 32'h40325193, 0, "srai");
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, 64,    32'h00001013, 1, "sh_ovf");
    tbl[8]  = mk(1, 10, 2, 0, 3, 0, 2047, 32'h7FF13503, 0, "ld_max");
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, -2048, 32'h80000013, 0, "i_min");
    tbl[10] = mk(3, 0, 0, 0, 0, 0, 4094,  32'h7E000FE3, 0, "b_max");
    tbl[11] = mk(3, 0, 0, 0, 0, 0, 4096,  32'h80000063, 1, "b_ovf");
    tbl[12] = mk(2, 0, 0, 0, 0, 0, -2049, 32'h7E000FA3, 1, "s_ovf");
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_enc_count", enc_count, 0);
    chk("reset_chk_fail", chk_fail, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 13; i++) send(tbl[i]);
    @(negedge clk);
    chk("tbl_enc_count", enc_count, 13);
    chk("tbl_err_count", err_count, 5);
    chk("tbl_chk_fail", chk_fail, 0);

    // Backpressure: third bundle stalls with both stages full, then all drain back-to-back
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b0;
    b[0] = mk(0, 1, 0, 0, 0, 0, 1,    0, 0, "bp0");
    b[1] = mk(0, 2, 0, 0, 0, 0, 2048, 0, 0, "bp1");
    b[2] = mk(0, 3, 0, 0, 0, 0, 3,    0, 0, "bp2");
    for (int i = 0; i < 3; i++) m[i] = model(b[i].fmt, b[i].rd, b[i].rs1, b[i].rs2, b[i].f3, b[i].f7, b[i].imm);
    push(b[0]);
    push(b[1]);
    drive(b[2]);
    @(negedge clk);
    chk("bp_stall", in_ready, 0);
    chk("bp_head", {out_err, out_instr}, m[0]);
    repeat (2) @(negedge clk);
    chk("bp_hold", {out_err, out_instr}, m[0]);
    chk("bp_stall_hold", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w0_valid", out_valid, 1);
    chk("bp_w0", {out_err, out_instr}, m[0]);
    chk("bp_fill_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_w1_valid", out_valid, 1);
    chk("bp_w1", {out_err, out_instr}, m[1]);
    @(negedge clk);
    chk("bp_w2_valid", out_valid, 1);
    chk("bp_w2", {out_err, out_instr}, m[2]);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_drained", out_valid, 0);
    chk("bp_enc_count", enc_count, 3);
    chk("bp_err_count", err_count, 1);

    // Asynchronous reset with both stages occupied
    push(b[0]);
    push(b[1]);
    @(negedge clk);
    chk("full_valid", out_valid, 1);
    chk("full_stall", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_enc_count", enc_count, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_chk_fail", chk_fail, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    send(tbl[0]);
    @(negedge clk);
    chk("post_rst_enc_count", enc_count, 1);

    // Randomized traffic; counters are narrow so saturation is exercised
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(3) != 0;
      in_fmt    = 2'($urandom);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      in_imm    = rand_imm();
      out_ready = $urandom_range(3) != 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    chk("rnd_drained", sbq.size(), 0);
    chk("rnd_enc_count", enc_count, n_enc > CMAX ? CMAX : n_enc);
    chk("rnd_err_count", err_count, n_err > CMAX ? CMAX : n_err);
    chk("rnd_chk_fail", chk_fail, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
